mips_pipeline_exmem_stage: RTL and testbench



---
 rtl/mips_pipeline_pkg.sv | 31 +++
 rtl/mips_pipeline_skid.sv | 88 ++++++++
 rtl/mips_pipeline_exmem_stage.sv | 73 +++++++
 tb/tb_mips_pipeline_exmem_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipeline_pkg.sv
// rtl/mips_pipeline_pkg.sv - shared EX/MEM constants: ALU status bits, payload field offsets, payload width
//
// Purpose: common definitions for the EX/MEM stage and the memory stage that unpacks its payload.
// Payload layout, MSB to LSB: {exception, alu_status, alu_result, pass_through}.
package mips_pipeline_pkg;

    // ALU status bit indices
    localparam int ST_ZERO  = 0;
    localparam int ST_OVF   = 1;
    localparam int ST_CARRY = 2;
    localparam int ST_NEG   = 3;

    // Payload field offsets (LSB position of each field)
    function automatic int exmem_result_lsb(input int pass_w);
        return pass_w;
    endfunction

    function automatic int exmem_status_lsb(input int pass_w, input int word_w);
        return pass_w + word_w;
    endfunction

    function automatic int exmem_exc_bit(input int pass_w, input int word_w, input int status_w);
        return pass_w + word_w + status_w;
    endfunction

    // Total payload width: pass-through + result + status + exception bit
    function automatic int exmem_width(input int pass_w, input int word_w, input int status_w);
        return pass_w + word_w + status_w + 1;
    endfunction

endpackage

// File: rtl/mips_pipeline_skid.sv
// rtl/mips_pipeline_skid.sv - generic 1- or 2-entry in-order valid/ready buffer with synchronous flush
//
// Purpose: registers a W-bit payload behind a valid/ready handshake.
//   DEPTH=1: plain register; o_in_tready = !valid | i_out_tready (combinational from downstream).
//   DEPTH=2: skid buffer; o_in_tready depends only on registered occupancy.
// Ports:
//   i_clock, i_reset       clock, synchronous active-high reset
//   i_flush                drops all held entries and the current offer
//   i_in_tdata/tvalid      upstream offer; o_in_tready accept indication
//   o_out_tdata/tvalid     head entry; i_out_tready downstream consume
module mips_pipeline_skid #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_flush,
    input  logic [W-1:0] i_in_tdata,
    input  logic         i_in_tvalid,
    output logic         o_in_tready,
    output logic [W-1:0] o_out_tdata,
    output logic         o_out_tvalid,
    input  logic         i_out_tready
);

    logic [1:0]   r_count;
    logic         r_out_valid;
    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic         w_push;
    logic         w_pop;

    // Ready is forced high during reset so upstream never sees a stall while the stage is being cleared.
    generate
        if (DEPTH == 1) begin : g_plain
            assign o_in_tready = i_reset | !r_out_valid | i_out_tready;
        end else begin : g_skid
            assign o_in_tready = i_reset | (r_count != 2'd2);
        end
    endgenerate

    assign w_push       = i_in_tvalid & o_in_tready & !i_flush;
    assign w_pop        = r_out_valid & i_out_tready & !i_flush;
    assign o_out_tdata  = r_head;
    assign o_out_tvalid = r_out_valid;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count     <= 2'd0;
            r_out_valid <= 1'b0;
            r_head      <= '0;
            r_tail      <= '0;
        end else if (i_flush) begin
            r_count     <= 2'd0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_head      <= i_in_tdata;
                        r_count     <= 2'd1;
                        r_out_valid <= 1'b1;
                    end
                end
                2'd1: begin
                    // Simultaneous push and pop: the new entry replaces the head directly.
                    if (w_push && w_pop) begin
                        r_head <= i_in_tdata;
                    end else if (w_push) begin
                        r_tail  <= i_in_tdata;
                        r_count <= 2'd2;
                    end else if (w_pop) begin
                        r_count     <= 2'd0;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    // Full: ready is low, so only a pop can happen here.
                    if (w_pop) begin
                        r_head  <= r_tail;
                        r_count <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/mips_pipeline_exmem_stage.sv
// rtl/mips_pipeline_exmem_stage.sv - EX/MEM pipeline stage: payload packing, trap tagging, stall counter
//
// Purpose: packs {exception, aluStatus, aluResult, pipeIn} and registers it through a
// mips_pipeline_skid buffer; counts cycles where the head entry is held by the memory stage.
// Ports:
//   clock, reset            clock, synchronous active-high reset
//   pipeIn, aluResult,
//   aluStatus, trapOnOverflow  execute-side payload inputs
//   inValid / inReady       upstream handshake
//   flush                   discard buffered entries and the current offer
//   pipeOut / outValid / outReady  memory-stage handshake
//   stallCount              saturating count of outValid & !outReady cycles
module mips_pipeline_exmem_stage
    import mips_pipeline_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int PASS_W   = 64,
    parameter int STATUS_W = 4,
    parameter int DEPTH    = 2,
    parameter int CNT_W    = 16
) (
    input  logic                                                 clock,
    input  logic                                                 reset,
    input  logic [PASS_W-1:0]                                    pipeIn,
    input  logic [WORD_W-1:0]                                    aluResult,
    input  logic [STATUS_W-1:0]                                  aluStatus,
    input  logic                                                 trapOnOverflow,
    input  logic                                                 inValid,
    output logic                                                 inReady,
    input  logic                                                 flush,
    output logic [exmem_width(PASS_W, WORD_W, STATUS_W)-1:0]     pipeOut,
    output logic                                                 outValid,
    input  logic                                                 outReady,
    output logic [CNT_W-1:0]                                     stallCount
);

    localparam int OUT_W = exmem_width(PASS_W, WORD_W, STATUS_W);

    logic             w_exception;
    logic [OUT_W-1:0] w_packed;
    logic [CNT_W-1:0] r_stall_count;

    // Only trapping add/sub turn an overflow into an exception; the status itself is passed unchanged.
    assign w_exception = trapOnOverflow & aluStatus[ST_OVF];
    assign w_packed    = {w_exception, aluStatus, aluResult, pipeIn};

    mips_pipeline_skid #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_skid (
        .i_clock      (clock),
        .i_reset      (reset),
        .i_flush      (flush),
        .i_in_tdata   (w_packed),
        .i_in_tvalid  (inValid),
        .o_in_tready  (inReady),
        .o_out_tdata  (pipeOut),
        .o_out_tvalid (outValid),
        .i_out_tready (outReady)
    );

    // Saturating; flush deliberately leaves the count alone so it reflects total memory-side stall time.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (outValid && !outReady && !(&r_stall_count)) begin
            r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stallCount = r_stall_count;

endmodule

// File: tb/tb_mips_pipeline_exmem_stage.sv
// tb/tb_mips_pipeline_exmem_stage.sv - self-checking bench for mips_pipeline_exmem_stage
module tb_mips_pipeline_exmem_stage;

    localparam int PW = 64;
    localparam int WW = 32;
    localparam int SW = 4;
    localparam int CW = 4;
    localparam int OW = PW + WW + SW + 1;

    typedef logic [OW-1:0] pay_t;

    logic          clock = 1'b0;
    logic          reset;
    logic [PW-1:0] pipeIn;
    logic [WW-1:0] aluResult;
    logic [SW-1:0] aluStatus;
    logic          trapOnOverflow;
    logic          inValid;
    logic          inReady;
    logic          flush;
    logic [OW-1:0] pipeOut;
    logic          outValid;
    logic          outReady;
    logic [CW-1:0] stallCount;

    always #5 clock = ~clock;

    mips_pipeline_exmem_stage #(
        .WORD_W   (WW),
        .PASS_W   (PW),
        .STATUS_W (SW),
        .DEPTH    (2),
        .CNT_W    (CW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .pipeIn         (pipeIn),
        .aluResult      (aluResult),
        .aluStatus      (aluStatus),
        .trapOnOverflow (trapOnOverflow),
        .inValid        (inValid),
        .inReady        (inReady),
        .flush          (flush),
        .pipeOut        (pipeOut),
        .outValid       (outValid),
        .outReady       (outReady),
        .stallCount     (stallCount)
    );

    // Reference model: a queue of held entries, a saturating stall tally, and a flag that
    // pipeOut must still read zero because nothing has been accepted since reset.
    pay_t q[$];
    pay_t popped[$];
    int   m_stall;
    bit   m_zero;
    bit   m_acc;
    int   total;
    int   bad;

    function automatic pay_t pack(logic [PW-1:0] p, logic [WW-1:0] r, logic [SW-1:0] s, logic t);
        pay_t x;
        x = pay_t'(p);
        x = x | (pay_t'(r) << PW);
        x = x | (pay_t'(s) << (PW + WW));
        if (t && ((s >> 1) & 1) == 1) x = x | (pay_t'(1) << (OW - 1));
        return x;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit v, input logic [PW-1:0] p, input logic [WW-1:0] r,
                       input logic [SW-1:0] s, input bit t, input bit ordy, input bit fl, input bit rst);
        bit exp_rdy;
        bit pop;
        pay_t ent;
        reset = rst; inValid = v; pipeIn = p; aluResult = r; aluStatus = s;
        trapOnOverflow = t; outReady = ordy; flush = fl;
        #1;
        exp_rdy = rst ? 1'b1 : (q.size() < 2);
        check("in_ready", inReady, exp_rdy);
        if (!rst) begin
            check("out_valid", outValid, q.size() != 0);
            if (q.size() != 0) check("pipe_out", pipeOut, q[0]);
            else if (m_zero)   check("pipe_out_zero", pipeOut, 0);
            check("stall_count", stallCount, m_stall);
        end
        m_acc = v && exp_rdy && !fl && !rst;
        pop   = (q.size() != 0) && ordy && !fl;
        ent   = pack(p, r, s, t);
        @(posedge clock);
        #1;
        if (rst) begin
            q.delete();
            m_stall = 0;
            m_zero  = 1;
        end else begin
            if (q.size() != 0 && !ordy && m_stall < (2**CW - 1)) m_stall++;
            if (fl) q.delete();
            else begin
                if (pop) popped.push_back(q.pop_front());
                if (m_acc) begin
                    q.push_back(ent);
                    m_zero = 0;
                end
            end
        end
    endtask

    task automatic idle(input bit ordy);
        cyc(1'b0, '0, '0, '0, 1'b0, ordy, 1'b0, 1'b0);
    endtask

    initial begin
        int vals[3];
        int idx;
        int s0;
        int n;
        total = 0; bad = 0; m_stall = 0; m_zero = 1;
        vals[0] = 'h11; vals[1] = 'h22; vals[2] = 'h33;

        // reset
        cyc(0, '0, '0, '0, 0, 0, 0, 1);
        cyc(0, '0, '0, '0, 0, 0, 0, 1);
        check("rst_out_valid", outValid, 0);
        check("rst_pipe_out", pipeOut, 0);
        check("rst_stall", stallCount, 0);

        // streaming, 8 accepts back-to-back
        popped.delete();
        for (int i = 0; i < 8; i++) begin
            cyc(1, PW'(i), WW'(32'h100 + i), '0, 0, 1, 0, 0);
            check("stream_accept", m_acc, 1);
        end
        idle(1);
        idle(1);
        check("stream_count", popped.size(), 8);
        for (int i = 0; i < 8 && i < popped.size(); i++)
            check("stream_order", popped[i], pack(PW'(i), WW'(32'h100 + i), '0, 0));

        // back-pressure
        popped.delete();
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            cyc(idx < 3, PW'(vals[idx < 3 ? idx : 2]), '0, '0, 0, 0, 0, 0);
            if (m_acc) idx++;
        end
        check("bp_accepted", idx, 2);
        check("bp_in_ready_low", inReady, 0);
        n = 0;
        while ((idx < 3 || q.size() != 0) && n < 12) begin
            cyc(idx < 3, PW'(vals[idx < 3 ? idx : 2]), '0, '0, 0, 1, 0, 0);
            if (m_acc) idx++;
            n++;
        end
        check("bp_drain_bound", n < 12, 1);
        check("bp_count", popped.size(), 3);
        for (int i = 0; i < 3 && i < popped.size(); i++)
            check("bp_order", popped[i], pack(PW'(vals[i]), '0, '0, 0));
        check("bp_stall", stallCount, 3);

        // trap tagging
        cyc(1, 64'hA, '0, 4'b0010, 1, 1, 0, 0);
        check("trap_ovf_on", pipeOut[OW-1], 1);
        cyc(1, 64'hB, '0, 4'b0010, 0, 1, 0, 0);
        check("trap_ovf_off", pipeOut[OW-1], 0);
        cyc(1, 64'hC, '0, 4'b0001, 1, 1, 0, 0);
        check("trap_zero_only", pipeOut[OW-1], 0);
        idle(1);

        // flush with two held and an offer of 0x44
        cyc(1, 64'h55, '0, '0, 0, 0, 0, 0);
        cyc(1, 64'h66, '0, '0, 0, 0, 0, 0);
        s0 = int'(stallCount);
        popped.delete();
        cyc(1, 64'h44, '0, '0, 0, 1, 1, 0);
        check("flush_out_valid", outValid, 0);
        check("flush_in_ready", inReady, 1);
        check("flush_stall", stallCount, s0);
        idle(1);
        idle(1);
        check("flush_no_pop", popped.size(), 0);

        // randomized traffic
        for (int i = 0; i < 300; i++)
            cyc(($urandom % 4) != 0, {$urandom, $urandom}, $urandom, SW'($urandom),
                $urandom % 2, ($urandom % 3) != 0, ($urandom % 16) == 0, 0);

        // saturation
        cyc(0, '0, '0, '0, 0, 0, 0, 1);
        cyc(1, 64'h77, '0, '0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) idle(0);
        check("sat_stall", stallCount, 4'hF);

        // reset with one entry buffered
        cyc(0, '0, '0, '0, 0, 0, 0, 1);
        reset = 1'b0;
        #1;
        check("rst2_out_valid", outValid, 0);
        check("rst2_pipe_out", pipeOut, 0);
        check("rst2_stall", stallCount, 0);
        check("rst2_in_ready", inReady, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
